// File: rtl/r2r_pwm_pkg.sv
// Shared types and helpers for the hybrid R2R + PWM DAC driver family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package r2r_pwm_pkg;

  // Modulation style for the PWM LSB part of a sample.
  typedef enum logic {
    PWM_SPREAD = 1'b0,  // accumulator carry: highs spread evenly over the frame
    PWM_EDGE   = 1'b1   // single pulse aligned to the start of the frame
  } pwm_mode_e;

  localparam int unsigned DEF_R2R_BITS = 4;
  localparam int unsigned DEF_PWM_BITS = 12;

  // Frame length in clock cycles for a given PWM resolution.
  function automatic int unsigned frame_len(input int unsigned pwm_bits);
    return 32'd1 << pwm_bits;
  endfunction

endpackage

// File: rtl/r2r_pwm_ch.sv
// One DAC channel: holds the active sample, drives the static R2R code and the modulated PWM bit.
// Latency: outputs are registered, one cycle after the slot they belong to; a new sample shows from slot 0 after load.
// Backpressure: none; the channel takes a new sample only when the top pulses load.
module r2r_pwm_ch
  import r2r_pwm_pkg::*;
#(
  parameter int R2R_BITS = 4,
  parameter int PWM_BITS = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PWM_BITS-1:0]          slot,
  input  logic                         load,
  input  pwm_mode_e                    mode,
  input  logic [R2R_BITS+PWM_BITS-1:0] new_val,
  output logic [R2R_BITS-1:0]          r2r_out,
  output logic                         pwm_out
);

  logic [PWM_BITS-1:0] v_q, v_d;
  logic [R2R_BITS-1:0] r_q, r_d;
  logic [PWM_BITS-1:0] acc_q, acc_d;
  logic [R2R_BITS-1:0] r2r_q, r2r_d;
  logic                pwm_q, pwm_d;
  logic [PWM_BITS-1:0] acc_base;
  logic [PWM_BITS:0]   sum;

  // Next-state: sample capture at frame load, and the per-slot modulator.
  always_comb begin
    v_d      = v_q;
    r_d      = r_q;
    acc_d    = acc_q;
    pwm_d    = 1'b0;
    r2r_d    = r_q;
    // Restarting the accumulator every frame makes the pattern depend only on v.
    acc_base = (slot == '0) ? '0 : acc_q;
    sum      = {1'b0, acc_base} + {1'b0, v_q};
    if (mode == PWM_SPREAD) begin
      pwm_d = sum[PWM_BITS];
      acc_d = sum[PWM_BITS-1:0];
    end else begin
      pwm_d = (slot < v_q);
    end
    if (load) begin
      r_d = new_val[R2R_BITS+PWM_BITS-1:PWM_BITS];
      v_d = new_val[PWM_BITS-1:0];
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      r_q   <= '0;
      acc_q <= '0;
      r2r_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      r_q   <= r_d;
      acc_q <= acc_d;
      r2r_q <= r2r_d;
      pwm_q <= pwm_d;
    end
  end

  assign r2r_out = r2r_q;
  assign pwm_out = pwm_q;

endmodule

// File: rtl/r2r_pwm_mch.sv
// Multi-channel hybrid DAC driver: shared frame timebase, one-deep sample buffer, CH channel modulators.
// Latency: a sample accepted in frame k is played in frame k+1; pin outputs are registered (1 cycle after slot).
// Backpressure: dac_ready drops while the buffer is full and rises again the cycle after the frame load.
module r2r_pwm_mch
  import r2r_pwm_pkg::*;
#(
  parameter int CH       = 2,
  parameter int R2R_BITS = 4,
  parameter int PWM_BITS = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 mode,
  output logic                                 val_req,
  input  logic                                 dac_valid,
  output logic                                 dac_ready,
  input  logic [CH*(R2R_BITS+PWM_BITS)-1:0]    dac_val,
  output logic                                 underrun,
  output logic [CH*R2R_BITS-1:0]               r2r_out,
  output logic [CH-1:0]                        pwm_out
);

  localparam int W = R2R_BITS + PWM_BITS;

  logic [PWM_BITS-1:0] slot_q, slot_d;
  logic [CH*W-1:0]     pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  pwm_mode_e           active_mode_q, active_mode_d;
  logic                val_req_q, val_req_d;
  logic                underrun_q, underrun_d;
  logic                load_slot;
  logic                accept;
  logic                ch_load;

  assign dac_ready = ~pend_full_q;
  assign accept    = dac_valid & dac_ready;
  assign load_slot = (slot_q == '1);
  assign ch_load   = load_slot & pend_full_q;

  // Timebase, buffer and frame-load bookkeeping.
  always_comb begin
    slot_d        = slot_q + 1'b1;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    active_mode_d = active_mode_q;
    // slot_d is 0 exactly when the current slot is the last one.
    val_req_d     = load_slot;
    underrun_d    = load_slot & ~pend_full_q;
    if (accept) begin
      pend_d      = dac_val;
      pend_full_d = 1'b1;
    end
    if (load_slot) begin
      active_mode_d = pwm_mode_e'(mode);
      // Full buffer means ready was low, so no accept can collide with the drain.
      if (pend_full_q) begin
        pend_full_d = 1'b0;
      end
    end
  end

  // Shared state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      active_mode_q <= PWM_SPREAD;
      val_req_q     <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      active_mode_q <= active_mode_d;
      val_req_q     <= val_req_d;
      underrun_q    <= underrun_d;
    end
  end

  assign val_req  = val_req_q;
  assign underrun = underrun_q;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    r2r_pwm_ch #(
      .R2R_BITS (R2R_BITS),
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .slot    (slot_q),
      .load    (ch_load),
      .mode    (active_mode_q),
      .new_val (pend_q[k*W +: W]),
      .r2r_out (r2r_out[k*R2R_BITS +: R2R_BITS]),
      .pwm_out (pwm_out[k])
    );
  end

endmodule

// File: tb/tb_r2r_pwm_mch.sv
// Self-checking bench for r2r_pwm_mch with CH=2, R2R_BITS=4, PWM_BITS=4 (N=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_r2r_pwm_mch;

  localparam int CH = 2;
  localparam int RB = 4;
  localparam int PB = 4;
  localparam int N  = 16;
  localparam int W  = RB + PB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode = 1'b0;
  logic             val_req;
  logic             dac_valid = 1'b0;
  logic             dac_ready;
  logic [CH*W-1:0]  dac_val = '0;
  logic             underrun;
  logic [CH*RB-1:0] r2r_out;
  logic [CH-1:0]    pwm_out;

  r2r_pwm_mch #(.CH(CH), .R2R_BITS(RB), .PWM_BITS(PB)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .val_req   (val_req),
    .dac_valid (dac_valid),
    .dac_ready (dac_ready),
    .dac_val   (dac_val),
    .underrun  (underrun),
    .r2r_out   (r2r_out),
    .pwm_out   (pwm_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame-level view of the driver.
  int          m_slot;
  int          m_act [CH];
  bit          m_mode;
  logic [CH*W-1:0] pend_q_model [$];

  // Per-frame observations.
  logic [N-1:0]  cur_pat  [CH];
  logic [N-1:0]  done_pat [CH];
  logic [RB-1:0] done_r2r [CH];
  bit            done_und;
  int            acc_slot;

  typedef struct {
    logic [CH*W-1:0] dat;
    bit              md;
    logic [RB-1:0]   r2r0;
    logic [RB-1:0]   r2r1;
    logic [N-1:0]    pat0;
    logic [N-1:0]    pat1;
    int              hi0;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Count of highs before slot s+1 minus before slot s: even spreading by plain arithmetic.
  function automatic bit exp_pwm(input int v, input bit md, input int s);
    if (md) return (s < v);
    return (((s + 1) * v) / N) > ((s * v) / N);
  endfunction

  task automatic model_reset();
    m_slot = 0;
    m_mode = 1'b0;
    for (int k = 0; k < CH; k++) begin
      m_act[k]   = 0;
      cur_pat[k] = '0;
    end
    pend_q_model.delete();
  endtask

  // One clock: predict, clock, compare, update frame records.
  task automatic step();
    int s;
    bit acc;
    logic [CH-1:0]    e_pwm;
    logic [CH*RB-1:0] e_r2r;
    bit e_vreq, e_und;
    s   = m_slot;
    acc = dac_valid && (pend_q_model.size() == 0);
    chk("dac_ready", dac_ready, pend_q_model.size() == 0);
    for (int k = 0; k < CH; k++) begin
      e_pwm[k]          = exp_pwm(m_act[k] % N, m_mode, s);
      e_r2r[k*RB +: RB] = RB'(m_act[k] / N);
    end
    e_vreq = (s == N - 1);
    e_und  = (s == N - 1) && (pend_q_model.size() == 0);
    if (s == N - 1) begin
      if (pend_q_model.size() != 0) begin
        logic [CH*W-1:0] p;
        p = pend_q_model.pop_front();
        for (int k = 0; k < CH; k++) m_act[k] = int'(p[k*W +: W]);
      end
      m_mode = mode;
    end
    if (acc) pend_q_model.push_back(dac_val);
    m_slot = (s + 1) % N;
    @(posedge clk);
    #1;
    chk("pwm_out",  pwm_out,  e_pwm);
    chk("r2r_out",  r2r_out,  e_r2r);
    chk("val_req",  val_req,  e_vreq);
    chk("underrun", underrun, e_und);
    for (int k = 0; k < CH; k++) cur_pat[k][s] = pwm_out[k];
    if (s == N - 1) begin
      for (int k = 0; k < CH; k++) begin
        done_pat[k] = cur_pat[k];
        done_r2r[k] = r2r_out[k*RB +: RB];
        cur_pat[k]  = '0;
      end
      done_und = underrun;
    end
  endtask

  task automatic finish_frame();
    for (int i = 0; i < N; i++) begin
      int s;
      s = m_slot;
      step();
      if (s == N - 1) break;
    end
  endtask

  task automatic goto_slot(input int t);
    for (int i = 0; i < N && m_slot != t; i++) step();
  endtask

  task automatic offer(input logic [CH*W-1:0] d);
    bit ok;
    ok        = 1'b0;
    dac_val   = d;
    dac_valid = 1'b1;
    for (int i = 0; i < 4 * N; i++) begin
      bit rdy;
      int s;
      rdy = (pend_q_model.size() == 0);
      s   = m_slot;
      step();
      if (rdy) begin
        ok       = 1'b1;
        acc_slot = s;
        break;
      end
    end
    dac_valid = 1'b0;
    if (!ok) chk("offer_timeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{dat: 16'h0035, md: 1'b0, r2r0: 4'h3, r2r1: 4'h0, pat0: 16'h9248, pat1: 16'h0000, hi0: 5};
    vecs[1] = '{dat: 16'h0F7A, md: 1'b1, r2r0: 4'h7, r2r1: 4'h0, pat0: 16'h03FF, pat1: 16'h7FFF, hi0: 10};
    vecs[2] = '{dat: 16'hA10F, md: 1'b1, r2r0: 4'h0, r2r1: 4'hA, pat0: 16'h7FFF, pat1: 16'h0001, hi0: 15};
    vecs[3] = '{dat: 16'hF80F, md: 1'b0, r2r0: 4'h0, r2r1: 4'hF, pat0: 16'hFFFE, pat1: 16'hAAAA, hi0: 15};

    // Reset held across clock edges.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_r2r", r2r_out, 0);
    chk("rst_vreq", val_req, 0);
    chk("rst_und", underrun, 0);
    chk("rst_ready", dac_ready, 1);
    rst = 1'b0;

    // Table-driven frames: each sample played in its own frame after acceptance.
    foreach (vecs[i]) begin
      mode = vecs[i].md;
      offer(vecs[i].dat);
      finish_frame();
      finish_frame();
      chk("tbl_pat0", done_pat[0], vecs[i].pat0);
      chk("tbl_pat1", done_pat[1], vecs[i].pat1);
      chk("tbl_r2r0", done_r2r[0], vecs[i].r2r0);
      chk("tbl_r2r1", done_r2r[1], vecs[i].r2r1);
      chk("tbl_hi0", $countones(done_pat[0]), vecs[i].hi0);
    end

    // Handshake: second sample waits for the load to drain the buffer.
    mode = 1'b1;
    goto_slot(2);
    offer(16'h0305);
    offer(16'h0709);
    chk("hs_accept_slot", acc_slot, 0);
    finish_frame();
    chk("hs_pat_a", done_pat[0], 16'h001F);
    finish_frame();
    chk("hs_pat_b", done_pat[0], 16'h01FF);
    chk("hs_pat_b1", done_pat[1], 16'h007F);
    // Sample accepted the cycle before load is played in the very next frame.
    goto_slot(N - 2);
    offer(16'h0002);
    chk("late_accept_slot", acc_slot, N - 2);
    finish_frame();
    chk("late_no_und", done_und, 0);
    finish_frame();
    chk("late_pat", done_pat[0], 16'h0003);
    // Underrun: nothing offered, previous frame repeats.
    chk("und_pulse", done_und, 1);
    finish_frame();
    chk("und_repeat", done_pat[0], 16'h0003);
    chk("und_pulse2", done_und, 1);

    // Mode toggled mid-frame only takes effect from the next frame.
    mode = 1'b0;
    offer(16'h0035);
    finish_frame();
    goto_slot(7);
    mode = 1'b1;
    finish_frame();
    chk("mt_cur_frame", done_pat[0], 16'h9248);
    finish_frame();
    chk("mt_next_frame", done_pat[0], 16'h001F);

    // Randomized traffic against the model.
    for (int i = 0; i < 30 * N; i++) begin
      dac_valid = ($urandom_range(0, 9) == 0);
      dac_val   = CH*W'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      step();
    end
    dac_valid = 1'b0;

    // Asynchronous reset mid-frame clears outputs immediately.
    goto_slot(5);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_r2r", r2r_out, 0);
    chk("mrst_vreq", val_req, 0);
    chk("mrst_und", underrun, 0);
    chk("mrst_ready", dac_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mode = 1'b0;
    for (int i = 0; i < 2 * N; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
